// File: rtl/serial_addsub_if.sv
// Operand/result bundle for the bit-serial adder/subtractor.
// The master drives the request and operands; the slave returns status and the completed result.
interface serial_addsub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;

  modport master (
    output start, op, a, b,
    input  busy, done, result, cout
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, cout
  );
endinterface

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder/full-subtractor cell, one bit per clock, LSB first.
// The carry/borrow lives in a register between bits; the result is published only at completion.
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input logic           clk,
  input logic           rst,
  serial_addsub_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic             sop_q, sop_d;
  logic             c_q, c_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;

  logic             sBit;
  logic             cNext;

  // Single-bit cell: sum/difference share the XOR; only the carry vs. borrow term differs.
  always_comb begin
    sBit = sa_q[0] ^ sb_q[0] ^ c_q;
    if (sop_q) begin
      cNext = (~sa_q[0] & sb_q[0]) | (sb_q[0] & c_q) | (c_q & ~sa_q[0]);
    end else begin
      cNext = (sa_q[0] & sb_q[0]) | (sa_q[0] & c_q) | (sb_q[0] & c_q);
    end
  end

  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    sop_d    = sop_q;
    c_d      = c_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    result_d = result_q;
    cout_d   = cout_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          sa_d    = bus.a;
          sb_d    = bus.b;
          sop_d   = bus.op;
          c_d     = 1'b0;
          cnt_d   = '0;
          acc_d   = '0;
        end
      end
      RUN: begin
        acc_d = {sBit, acc_q[WIDTH-1:1]};
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        c_d   = cNext;
        cnt_d = cnt_q + 1'b1;
        // Last bit: publish the fully shifted accumulator and the final carry/borrow together.
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d  = DONE;
          result_d = {sBit, acc_q[WIDTH-1:1]};
          cout_d   = cNext;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      sop_q    <= 1'b0;
      c_q      <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      sop_q    <= sop_d;
      c_q      <= c_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      cout_q   <= cout_d;
    end
  end

  assign bus.busy   = (state_q != IDLE);
  assign bus.done   = (state_q == DONE);
  assign bus.result = result_q;
  assign bus.cout   = cout_q;
endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub: directed and random operations against an arithmetic model,
// checking latency, result holding, ignored starts, abort on reset and back-to-back throughput.
module tb_serial_addsub;
  localparam int WIDTH = 8;

  logic clk;
  logic rst;
  int   checks;
  int   fails;
  logic [WIDTH-1:0] lastResult;
  logic             lastCout;

  serial_addsub_if #(.WIDTH(WIDTH)) bus ();

  serial_addsub #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: WIDTH+1-bit arithmetic; the top bit is the carry for add and the borrow for subtract.
  function automatic logic [WIDTH:0] refModel(input logic op, input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    logic [WIDTH:0] ext;
    if (op) ext = {1'b0, a} - {1'b0, b};
    else    ext = {1'b0, a} + {1'b0, b};
    return ext;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      fails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One operation; when glitch is set, extra start pulses with new operands are fired mid-run.
  task automatic applyStimulus(input string tag, input logic op, input logic [WIDTH-1:0] a,
                               input logic [WIDTH-1:0] b, input bit glitch);
    logic [WIDTH:0] exp;
    int n;
    int extraDone;
    exp = refModel(op, a, b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(negedge clk);
    bus.start = 1'b0;
    checkOutput({tag, "_busy"}, 32'(bus.busy), 32'd1);
    n = 0;
    while (n < WIDTH + 4) begin
      checkOutput({tag, "_hold"}, {23'd0, bus.cout, bus.result}, {23'd0, lastCout, lastResult});
      if (glitch && (n == 3 || n == 7)) begin
        bus.start = 1'b1;
        bus.op    = ~op;
        bus.a     = WIDTH'($urandom);
        bus.b     = WIDTH'($urandom);
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      n++;
      if (bus.done) break;
    end
    bus.start = 1'b0;
    checkOutput({tag, "_latency"}, 32'(n), 32'(WIDTH));
    checkOutput({tag, "_result"}, 32'(bus.result), 32'(exp[WIDTH-1:0]));
    checkOutput({tag, "_cout"}, 32'(bus.cout), 32'(exp[WIDTH]));
    lastResult = exp[WIDTH-1:0];
    lastCout   = exp[WIDTH];
    @(negedge clk);
    checkOutput({tag, "_donefall"}, {30'd0, bus.busy, bus.done}, 32'd0);
    if (glitch) begin
      extraDone = 0;
      repeat (WIDTH + 3) begin
        @(negedge clk);
        if (bus.done || bus.busy) extraDone++;
      end
      checkOutput({tag, "_noextra"}, 32'(extraDone), 32'd0);
    end
  endtask

  task automatic resetDut();
    rst       = 1'b1;
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    lastResult = '0;
    lastCout   = 1'b0;
  endtask

  task automatic backToBack(input int nOps);
    logic [WIDTH:0] expQ[$];
    logic [WIDTH:0] exp;
    logic           op;
    logic [WIDTH-1:0] a, b;
    int cyc, seen, lastDoneCyc;
    @(negedge clk);
    op = 1'($urandom); a = WIDTH'($urandom); b = WIDTH'($urandom);
    bus.op = op; bus.a = a; bus.b = b; bus.start = 1'b1;
    expQ.push_back(refModel(op, a, b));
    cyc = 0; seen = 0; lastDoneCyc = 0;
    while (seen < nOps && cyc < nOps * (WIDTH + 2) + 20) begin
      @(negedge clk);
      cyc++;
      if (bus.done) begin
        exp = expQ.pop_front();
        checkOutput("b2b_result", {23'd0, bus.cout, bus.result}, {23'd0, exp});
        if (seen > 0) checkOutput("b2b_interval", 32'(cyc - lastDoneCyc), 32'(WIDTH + 2));
        lastDoneCyc = cyc;
        lastResult  = exp[WIDTH-1:0];
        lastCout    = exp[WIDTH];
        seen++;
        if (seen < nOps) begin
          op = 1'($urandom); a = WIDTH'($urandom); b = WIDTH'($urandom);
          bus.op = op; bus.a = a; bus.b = b;
          expQ.push_back(refModel(op, a, b));
        end else begin
          bus.start = 1'b0;
        end
      end else begin
        checkOutput("b2b_stable", {23'd0, bus.cout, bus.result}, {23'd0, lastCout, lastResult});
      end
    end
    bus.start = 1'b0;
    checkOutput("b2b_count", 32'(seen), 32'(nOps));
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int n;
    int doneSeen;
    checks    = 0;
    fails     = 0;
    bus.start = 1'b0;
    bus.op    = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    resetDut();
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_done", 32'(bus.done), 32'd0);
    checkOutput("rst_result", 32'(bus.result), 32'd0);
    checkOutput("rst_cout", 32'(bus.cout), 32'd0);

    applyStimulus("add_5a_3c", 1'b0, 8'h5A, 8'h3C, 1'b0);
    checkOutput("add_5a_3c_const", {23'd0, bus.cout, bus.result}, {23'd0, 1'b0, 8'h96});
    applyStimulus("add_ff_01", 1'b0, 8'hFF, 8'h01, 1'b0);
    checkOutput("add_ff_01_const", {23'd0, bus.cout, bus.result}, {23'd0, 1'b1, 8'h00});
    applyStimulus("add_00_00", 1'b0, 8'h00, 8'h00, 1'b0);
    applyStimulus("sub_5a_3c", 1'b1, 8'h5A, 8'h3C, 1'b0);
    checkOutput("sub_5a_3c_const", {23'd0, bus.cout, bus.result}, {23'd0, 1'b0, 8'h1E});
    applyStimulus("sub_3c_5a", 1'b1, 8'h3C, 8'h5A, 1'b0);
    checkOutput("sub_3c_5a_const", {23'd0, bus.cout, bus.result}, {23'd0, 1'b1, 8'hE2});
    applyStimulus("sub_00_01", 1'b1, 8'h00, 8'h01, 1'b0);
    checkOutput("sub_00_01_const", {23'd0, bus.cout, bus.result}, {23'd0, 1'b1, 8'hFF});

    applyStimulus("glitch_add", 1'b0, 8'hA7, 8'h6B, 1'b1);
    applyStimulus("glitch_sub", 1'b1, 8'h12, 8'hC4, 1'b1);

    for (int i = 0; i < 12; i++) begin
      applyStimulus("rand", 1'($urandom), WIDTH'($urandom), WIDTH'($urandom), 1'b0);
    end

    // Abort mid-run: reset during the fourth RUN cycle must clear everything with no done pulse.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 1'b0; bus.a = 8'h77; bus.b = 8'h55;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort_busy", 32'(bus.busy), 32'd0);
    checkOutput("abort_done", 32'(bus.done), 32'd0);
    checkOutput("abort_result", 32'(bus.result), 32'd0);
    checkOutput("abort_cout", 32'(bus.cout), 32'd0);
    lastResult = '0;
    lastCout   = 1'b0;
    doneSeen = 0;
    for (n = 0; n < WIDTH + 4; n++) begin
      @(negedge clk);
      if (bus.done) doneSeen++;
    end
    checkOutput("abort_nodone", 32'(doneSeen), 32'd0);
    applyStimulus("after_abort", 1'b1, 8'h80, 8'h01, 1'b0);

    backToBack(5);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
